// File: rtl/conv_layer_mc.sv
// Multi-channel KxK convolution over a raster pixel stream.
// Line buffers feed a shift window; two-stage MAC / bias+ReLU pipeline.
module conv_layer_mc #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int DATA_BITS = 8,
  parameter int K         = 3,
  parameter int NUM_CH    = 4,
  parameter int OUT_BITS  = 22,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW = $clog2(K*K)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_BITS-1:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_CH*OUT_BITS-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  input  logic                       cfg_relu,
  input  logic                       cfg_stride2,
  input  logic                       w_we,
  input  logic                       b_we,
  input  logic [CW-1:0]              w_ch,
  input  logic [AW-1:0]              w_addr,
  input  logic [DATA_BITS-1:0]       w_data,
  output logic                       busy
);

  localparam int KK  = K*K;
  localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LC2 = K - 1 + 2*((IMG_W - K)/2);
  localparam int LR2 = K - 1 + 2*((IMG_H - K)/2);
  localparam int EXT = OUT_BITS - DATA_BITS;
  localparam bit KP  = 1'((K - 1) % 2);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t state, state_nx;
  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic relu_q, s2_q;
  logic en, accept, wr_ok;
  logic win_ok, last_ok, frame_end;
  logic v0, l0, v1, l1;

  logic        [DATA_BITS-1:0] lb   [K-1][IMG_W];
  logic        [DATA_BITS-1:0] win  [K][K];
  logic        [DATA_BITS-1:0] tap  [K];
  logic signed [DATA_BITS-1:0] wt   [NUM_CH][KK];
  logic signed [DATA_BITS-1:0] bias [NUM_CH];
  logic signed [OUT_BITS-1:0]  sum_c [NUM_CH];
  logic signed [OUT_BITS-1:0]  s1    [NUM_CH];
  logic signed [OUT_BITS-1:0]  res   [NUM_CH];

  function automatic logic signed [OUT_BITS-1:0] pext(
    input logic [DATA_BITS-1:0] p
  );
    return $signed({{EXT{1'b0}}, p});
  endfunction

  function automatic logic signed [OUT_BITS-1:0] sext(
    input logic [DATA_BITS-1:0] w
  );
    return $signed({{EXT{w[DATA_BITS-1]}}, w});
  endfunction

  assign en     = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  assign busy   = (state != IDLE);
  assign wr_ok  = (state == IDLE) && !accept;

  always_comb begin
    unique case (state)
      IDLE:    in_ready = 1'b1;
      STREAM:  in_ready = en;
      default: in_ready = 1'b0;
    endcase
  end

  assign frame_end = (col == XW'(IMG_W-1)) && (row == YW'(IMG_H-1));

  // Stride-2 parity: (col-(K-1)) even <=> col[0] matches parity of K-1
  always_comb begin
    win_ok = (col >= XW'(K-1)) && (row >= YW'(K-1));
    if (s2_q)
      win_ok = win_ok && (col[0] == KP) && (row[0] == KP);
    if (s2_q)
      last_ok = (col == XW'(LC2)) && (row == YW'(LR2));
    else
      last_ok = frame_end;
  end

  always_comb begin
    tap[0] = in_data;
    for (int i = 1; i < K; i++)
      tap[i] = lb[i-1][col];
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      sum_c[c] = '0;
      for (int r = 0; r < K; r++)
        for (int k = 0; k < K; k++)
          sum_c[c] = sum_c[c]
                   + pext(win[r][k]) * sext(wt[c][r*K+k]);
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      res[c] = s1[c] + sext(bias[c]);
      if (relu_q && res[c][OUT_BITS-1])
        res[c] = '0;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (accept) state_nx = STREAM;
      STREAM: if (accept && frame_end) state_nx = FLUSH;
      FLUSH:  if (!v0 && !v1 && en) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      relu_q    <= 1'b0;
      s2_q      <= 1'b0;
      v0        <= 1'b0;
      l0        <= 1'b0;
      v1        <= 1'b0;
      l1        <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < K-1; i++)
        for (int j = 0; j < IMG_W; j++)
          lb[i][j] <= '0;
      for (int r = 0; r < K; r++)
        for (int k = 0; k < K; k++)
          win[r][k] <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        bias[c] <= '0;
        s1[c]   <= '0;
        for (int a = 0; a < KK; a++)
          wt[c][a] <= '0;
      end
    end else begin
      state <= state_nx;
      if (wr_ok && w_we && int'(w_ch) < NUM_CH && int'(w_addr) < KK)
        wt[w_ch][w_addr] <= w_data;
      if (wr_ok && b_we && int'(w_ch) < NUM_CH)
        bias[w_ch] <= w_data;
      if (state == IDLE && accept) begin
        relu_q <= cfg_relu;
        s2_q   <= cfg_stride2;
      end
      if (en) begin
        v0 <= accept && win_ok;
        l0 <= accept && win_ok && last_ok;
        v1 <= v0;
        l1 <= l0;
        s1 <= sum_c;
        out_valid <= v1;
        out_last  <= l1;
        if (v1)
          for (int c = 0; c < NUM_CH; c++)
            out_data[c*OUT_BITS +: OUT_BITS] <= res[c];
      end
      if (accept) begin
        if (col == XW'(IMG_W-1)) begin
          col <= '0;
          row <= (row == YW'(IMG_H-1)) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        lb[0][col] <= in_data;
        for (int i = 1; i < K-1; i++)
          lb[i][col] <= lb[i-1][col];
        for (int r = 0; r < K; r++) begin
          for (int k = 0; k < K-1; k++)
            win[r][k] <= win[r][k+1];
          win[r][K-1] <= tap[K-1-r];
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_mc.sv
// Directed bench for conv_layer_mc on a 6x6 frame, K=3, two channels.
// Expected beats come from a small weight/bias model of the convolution.
module tb_conv_layer_mc;

  localparam int W  = 6;
  localparam int H  = 6;
  localparam int OB = 22;

  logic          clk = 0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [2*OB-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          cfg_relu;
  logic          cfg_stride2;
  logic          w_we;
  logic          b_we;
  logic [0:0]    w_ch;
  logic [3:0]    w_addr;
  logic [7:0]    w_data;
  logic          busy;

  conv_layer_mc #(
    .IMG_W(W), .IMG_H(H), .DATA_BITS(8),
    .K(3), .NUM_CH(2), .OUT_BITS(OB)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last),
    .cfg_relu(cfg_relu), .cfg_stride2(cfg_stride2),
    .w_we(w_we), .b_we(b_we), .w_ch(w_ch),
    .w_addr(w_addr), .w_data(w_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*OB-1:0] d;
    logic            l;
  } beat_t;

  beat_t q[$];
  int ncmp = 0;
  int nerr = 0;
  int wm [2][9];
  int bm [2];

  always @(negedge clk)
    if (!rst && out_valid && out_ready)
      q.push_back('{out_data, out_last});

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] got(input int i, input int c);
    logic signed [OB-1:0] v;
    if (i >= q.size()) return 64'sd999999;
    v = q[i].d[c*OB +: OB];
    return v;
  endfunction

  function automatic logic signed [63:0] expv(input int c, input bit ramp,
                                              input int x, input int y,
                                              input bit relu);
    longint a;
    a = bm[c];
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 3; k++)
        a += wm[c][r*3+k] * (ramp ? (y+r)*W + (x+k) : 10);
    if (relu && a < 0) a = 0;
    return a;
  endfunction

  task automatic wr(input int ch, input int addr,
                    input int val, input bit isb);
    w_we   = !isb;
    b_we   = isb;
    w_ch   = 1'(ch);
    w_addr = 4'(addr);
    w_data = 8'(val);
    @(posedge clk); #1;
    w_we = 0;
    b_we = 0;
  endtask

  task automatic load(input int ch, input int wv, input int bv);
    for (int a = 0; a < 9; a++) begin
      wr(ch, a, wv, 0);
      wm[ch][a] = wv;
    end
    wr(ch, 0, bv, 1);
    bm[ch] = bv;
  endtask

  task automatic send_frame(input bit ramp, input bit s2, input bit relu,
                            input int n, input int inj, input bit tog);
    int t;
    cfg_relu    = relu;
    cfg_stride2 = s2;
    for (int i = 0; i < n; i++) begin
      in_data  = ramp ? 8'(i) : 8'd10;
      in_valid = 1;
      if (i == inj) begin
        w_we = 1; w_ch = 0; w_addr = 4; w_data = 8'd7;
      end
      if (tog && i == 10) cfg_relu = !cfg_relu;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      w_we = 0;
    end
    in_valid = 0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_idle"}, busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic check_frame(input string tag, input bit ramp,
                             input bit s2, input bit relu);
    int st, tot, n;
    st  = s2 ? 2 : 1;
    tot = s2 ? 4 : 16;
    n   = 0;
    chk({tag, "_count"}, q.size(), tot);
    for (int y = 0; y <= 3; y += st)
      for (int x = 0; x <= 3; x += st) begin
        chk($sformatf("%s_b%0d_c0", tag, n), got(n, 0),
            expv(0, ramp, x, y, relu));
        chk($sformatf("%s_b%0d_c1", tag, n), got(n, 1),
            expv(1, ramp, x, y, relu));
        chk($sformatf("%s_b%0d_last", tag, n),
            (n < q.size()) ? 64'(q[n].l) : 64'sd9,
            (n == tot-1) ? 1 : 0);
        n++;
      end
  endtask

  task automatic stall_proc();
    int t;
    logic [2*OB-1:0] hd;
    logic hl;
    t = 0;
    while (q.size() < 2 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    out_ready = 0;
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("stall_valid", out_valid, 1);
    hd = out_data;
    hl = out_last;
    repeat (5) begin
      @(negedge clk);
      chk("stall_data", out_data, hd);
      chk("stall_last", out_last, hl);
      chk("stall_valid_hold", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1;
  endtask

  initial begin
    rst = 1; in_data = 0; in_valid = 0; out_ready = 1;
    cfg_relu = 0; cfg_stride2 = 0;
    w_we = 0; b_we = 0; w_ch = 0; w_addr = 0; w_data = 0;
    for (int c = 0; c < 2; c++) begin
      bm[c] = 0;
      for (int a = 0; a < 9; a++) wm[c][a] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    load(0, 1, 0);
    load(1, 2, 3);

    q.delete();
    send_frame(0, 0, 0, 36, -1, 0);
    wait_idle("t1");
    check_frame("t1", 0, 0, 0);
    chk("t1_ch0", got(0, 0), 90);
    chk("t1_ch1", got(15, 1), 183);

    q.delete();
    send_frame(1, 1, 0, 36, -1, 0);
    wait_idle("t2");
    check_frame("t2", 1, 1, 0);
    chk("t2_w00", got(0, 0), 63);
    chk("t2_w20", got(1, 0), 81);
    chk("t2_w02", got(2, 0), 171);
    chk("t2_w22", got(3, 0), 189);

    q.delete();
    fork
      send_frame(1, 0, 0, 36, -1, 0);
      stall_proc();
    join
    wait_idle("t3");
    check_frame("t3", 1, 0, 0);

    q.delete();
    send_frame(0, 0, 0, 36, 15, 0);
    wait_idle("t4a");
    check_frame("t4a", 0, 0, 0);
    chk("t4a_ch0", got(5, 0), 90);
    wr(0, 4, 7, 0);
    wm[0][4] = 7;
    q.delete();
    send_frame(0, 0, 0, 36, -1, 0);
    wait_idle("t4b");
    check_frame("t4b", 0, 0, 0);
    chk("t4b_ch0", got(0, 0), 150);

    load(0, -1, 5);
    q.delete();
    send_frame(0, 0, 0, 36, -1, 1);
    wait_idle("t5a");
    check_frame("t5a", 0, 0, 0);
    chk("t5a_ch0", got(15, 0), -85);
    q.delete();
    send_frame(0, 0, 1, 36, -1, 1);
    wait_idle("t5b");
    check_frame("t5b", 0, 0, 1);
    chk("t5b_ch0", got(3, 0), 0);
    chk("t5b_ch1", got(3, 1), 183);

    send_frame(1, 0, 0, 20, -1, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_in_ready", in_ready, 1);
    for (int c = 0; c < 2; c++) begin
      bm[c] = 0;
      for (int a = 0; a < 9; a++) wm[c][a] = 0;
    end
    load(0, 1, 0);
    load(1, 2, 3);
    q.delete();
    send_frame(1, 0, 0, 36, -1, 0);
    wait_idle("t6");
    check_frame("t6", 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
